// File: rtl/rv_mem_pkg.sv
// Shared definitions for the fetch/data memory arbiter: default widths,
// port index constants and the arbiter FSM state encoding.
package rv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam int PORT_IF = 0;
  localparam int PORT_D  = 1;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } arbState_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins at once, a tie goes to the
// port that was not granted most recently.
module rr_arb2
  import rv_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // Remembers whether the data port holds the most recent grant
  logic lastD_q, lastD_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[PORT_IF] && req_i[PORT_D]) begin
      if (lastD_q) gnt_o[PORT_IF] = 1'b1;
      else         gnt_o[PORT_D]  = 1'b1;
    end else begin
      gnt_o = req_i;
    end

    lastD_d = lastD_q;
    if (gnt_o[PORT_D])       lastD_d = 1'b1;
    else if (gnt_o[PORT_IF]) lastD_d = 1'b0;
  end

  // Reset to "fetch last" so data wins the first tie
  always_ff @(posedge clk) begin
    if (rst) lastD_q <= 1'b0;
    else     lastD_q <= lastD_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between an instruction
// fetch port and a load/store data port.
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                stall,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [15:0]         conflict_cnt
);

  arbState_e         state_q;
  logic [15:0]       conflictCnt_q, conflictCnt_d;
  logic [DATA_W-1:0] ifRdata_q, dRdata_q;
  logic              ifElig, dElig;
  logic [1:0]        req, gnt;
  logic [ADDR_W-1:0] selAddr;

  // A port in its response cycle still holds req high; it must not reissue
  assign ifElig = if_req & ~rst & (state_q != RESP_IF);
  assign dElig  = d_req  & ~rst & (state_q != RESP_D);

  always_comb begin
    req          = 2'b00;
    req[PORT_IF] = ifElig;
    req[PORT_D]  = dElig;
  end

  rr_arb2 uArb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_wdata = '0;
    selAddr   = '0;
    if (gnt[PORT_D]) begin
      mem_en    = 1'b1;
      selAddr   = d_addr;
      mem_wdata = d_wdata;
      if (d_we) mem_we = d_wstrb;
    end else if (gnt[PORT_IF]) begin
      mem_en  = 1'b1;
      selAddr = if_addr;
    end
  end

  // Byte offset is dropped silently; the memory only sees word addresses
  assign mem_addr = selAddr & ~{{(ADDR_W-2){1'b0}}, 2'b11};

  assign if_valid = (state_q == RESP_IF) & ~rst;
  assign d_valid  = (state_q == RESP_D)  & ~rst;
  assign if_rdata = if_valid ? mem_rdata : ifRdata_q;
  assign d_rdata  = d_valid  ? mem_rdata : dRdata_q;
  assign stall    = (if_req & ~if_valid) | (d_req & ~d_valid);

  assign conflict_cnt = conflictCnt_q;

  always_comb begin
    conflictCnt_d = conflictCnt_q;
    if (ifElig && dElig && (conflictCnt_q != CNT_MAX))
      conflictCnt_d = conflictCnt_q + 16'd1;
  end

  // The state after an issue names the port whose response is due next
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      conflictCnt_q <= '0;
      ifRdata_q     <= '0;
      dRdata_q      <= '0;
    end else begin
      if (gnt[PORT_D])       state_q <= RESP_D;
      else if (gnt[PORT_IF]) state_q <= RESP_IF;
      else                   state_q <= IDLE;
      conflictCnt_q <= conflictCnt_d;
      if (if_valid) ifRdata_q <= mem_rdata;
      if (d_valid)  dRdata_q  <= mem_rdata;
    end
  end

endmodule
